// File: rtl/st2mm_vdm_rx_buffer.sv
// Store-and-forward buffer for MCTP VDM TLPs leaving the ST2MM packet filter.
// Latency: m_tvalid rises 2 clk after the tlast handshake of a packet into an empty buffer; 1 beat/clk streaming.
// Backpressure: never stalls the sink (s_tready=1 out of reset); packets that do not fit or are oversize are dropped.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   s_tvalid/tready/tdata/tkeep/tlast/tuser   AXI-S sink from the filter UMSG output
//   m_tvalid/tready/tdata/tkeep/tlast/tuser   AXI-S source to the MCTP/PMCI consumer
//   pkt_cnt                      complete packets currently held (including the one being output)
//   drop_cnt                     saturating dropped-packet count
//
// Build option: define ST2MM_VDM_RXBUF_DROP_CNT_EN to enable the drop counter;
// otherwise drop_cnt is tied to zero and drop behaviour is unchanged.
module st2mm_vdm_rx_buffer #(
   parameter int TDATA_WIDTH   = 512,
   parameter int TUSER_WIDTH   = 10,
   parameter int DEPTH         = 64,
   parameter int MAX_PKT_BEATS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   input  logic [TDATA_WIDTH-1:0]       s_tdata,
   input  logic [TDATA_WIDTH/8-1:0]     s_tkeep,
   input  logic                         s_tlast,
   input  logic [TUSER_WIDTH-1:0]       s_tuser,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [TDATA_WIDTH-1:0]       m_tdata,
   output logic [TDATA_WIDTH/8-1:0]     m_tkeep,
   output logic                         m_tlast,
   output logic [TUSER_WIDTH-1:0]       m_tuser,
   output logic [$clog2(DEPTH):0]       pkt_cnt,
   output logic [15:0]                  drop_cnt
);
   localparam int KW = TDATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;
   localparam int CW = $clog2(MAX_PKT_BEATS + 1);

   typedef enum logic [1:0] {IDLE, STORE, DISCARD} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [PW-1:0]   wr_ptr, wr_commit_ptr, rd_ptr;
   logic [PW-1:0]   free;
   logic            has_space, beat;
   logic            wr_en, commit, rewind;

   logic [EW-1:0]   mem [DEPTH];
   logic            r_vld, r_take, rd_en, avail, pop_last, o_last;
   logic [EW-1:0]   r_dat, o_dat;

   // Extra pointer bit distinguishes full from empty; uncommitted beats count as used.
   assign free      = PW'(DEPTH) - (wr_ptr - rd_ptr);
   assign has_space = (free >= PW'(MAX_PKT_BEATS));
   assign beat      = s_tvalid & s_tready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      commit    = 1'b0;
      rewind    = 1'b0;
      case (state)
         IDLE: if (beat) begin
            // Space for a worst-case packet is reserved at SOP, so a stored packet can never overflow.
            if (has_space) begin
               wr_en   = 1'b1;
               cnt_nxt = CW'(1);
               if (s_tlast) commit = 1'b1;
               else         state_nxt = STORE;
            end else if (!s_tlast) begin
               state_nxt = DISCARD;
            end
         end
         STORE: if (beat) begin
            if (cnt == CW'(MAX_PKT_BEATS)) begin
               // Oversize: forget everything written since the last commit.
               rewind    = 1'b1;
               state_nxt = s_tlast ? IDLE : DISCARD;
            end else begin
               wr_en   = 1'b1;
               cnt_nxt = cnt + CW'(1);
               if (s_tlast) begin
                  commit    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         DISCARD: if (beat && s_tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_tready      <= 1'b0;
         cnt           <= '0;
         wr_ptr        <= '0;
         wr_commit_ptr <= '0;
      end else begin
         s_tready <= 1'b1;
         cnt      <= cnt_nxt;
         if (rewind)     wr_ptr <= wr_commit_ptr;
         else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (commit)     wr_commit_ptr <= wr_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast, s_tuser};
   end

   // Read side: RAM output register feeding the output register. Only committed
   // beats are fetched, so rd_ptr never reaches an address being written.
   assign avail    = (wr_commit_ptr != rd_ptr);
   assign r_take   = r_vld & (~m_tvalid | m_tready);
   assign rd_en    = avail & (~r_vld | r_take);
   assign pop_last = m_tvalid & m_tready & m_tlast;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         r_vld    <= 1'b0;
         m_tvalid <= 1'b0;
         pkt_cnt  <= '0;
      end else begin
         if (rd_en)       rd_ptr <= rd_ptr + PW'(1);
         if (rd_en)       r_vld  <= 1'b1;
         else if (r_take) r_vld  <= 1'b0;
         if (~m_tvalid | m_tready) m_tvalid <= r_vld;
         if (commit & ~pop_last)      pkt_cnt <= pkt_cnt + PW'(1);
         else if (~commit & pop_last) pkt_cnt <= pkt_cnt - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en)  r_dat <= mem[rd_ptr[AW-1:0]];
      if (r_take) o_dat <= r_dat;
   end

   assign {m_tdata, m_tkeep, o_last, m_tuser} = o_dat;
   assign m_tlast = m_tvalid & o_last;

`ifdef ST2MM_VDM_RXBUF_DROP_CNT_EN
   logic        drop_evt;
   logic [15:0] drop_q;
   assign drop_evt = rewind | ((state == IDLE) & beat & ~has_space);
   always_ff @(posedge clk) begin
      if (!rst_n)                            drop_q <= '0;
      else if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
   end
   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_st2mm_vdm_rx_buffer.sv
// Testbench for st2mm_vdm_rx_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
// Model: packets accepted when buffer has room for a maximum packet, oversize ones discarded.
module tb_st2mm_vdm_rx_buffer;
   localparam int DW    = 64;
   localparam int UW    = 10;
   localparam int DEPTH = 64;
   localparam int MAXB  = 16;
   localparam int KW    = DW / 8;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int EW    = DW + KW + 1 + UW;
`ifdef ST2MM_VDM_RXBUF_DROP_CNT_EN
   localparam int DCE = 1;
`else
   localparam int DCE = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_tvalid = 1'b0, s_tready;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tlast = 1'b0;
   logic [UW-1:0] s_tuser = '0;
   logic          m_tvalid, m_tready = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic [UW-1:0] m_tuser;
   logic [PW-1:0] pkt_cnt;
   logic [15:0]   drop_cnt;

   always #5 clk = ~clk;

   st2mm_vdm_rx_buffer #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tuser(m_tuser),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] cur[$];
   int  occ = 0, pkt_m = 0, drops_m = 0;
   bit  in_pkt = 0, accepting = 0, rdy_exp = 0, armed = 0, prev_stall = 0;
   logic [EW-1:0] prev_out;

   function automatic int drop_exp();
      if (DCE == 0) return 0;
      return (drops_m > 65535) ? 65535 : drops_m;
   endfunction

   task automatic model_commit();
      foreach (cur[i]) exp_q.push_back(cur[i]);
      cur.delete();
      pkt_m++;
      in_pkt    = 0;
      accepting = 0;
   endtask

   task automatic model_beat(input logic [EW-1:0] b, input logic last);
      if (!in_pkt) begin
         if (DEPTH - occ >= MAXB) begin
            accepting = 1;
            cur.delete();
            cur.push_back(b);
            occ++;
            in_pkt = 1;
            if (last) model_commit();
         end else begin
            drops_m++;
            accepting = 0;
            in_pkt = !last;
         end
      end else if (accepting) begin
         if (cur.size() == MAXB) begin
            occ -= MAXB;
            drops_m++;
            cur.delete();
            accepting = 0;
            if (last) in_pkt = 0;
         end else begin
            cur.push_back(b);
            occ++;
            if (last) model_commit();
         end
      end else if (last) begin
         in_pkt = 0;
      end
   endtask

   // Compare process: checks the state left by the previous edge, then advances
   // the model for the edge about to happen.
   always @(negedge clk) begin
      logic [EW-1:0] out;
      out = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (armed) begin
         chk("s_tready", s_tready, rdy_exp);
         chk("pkt_cnt", pkt_cnt, pkt_m);
         chk("drop_cnt", drop_cnt, drop_exp());
         if (prev_stall) begin
            chk("stall_vld", m_tvalid, 1);
            chk("stall_dat", out, prev_out);
         end
         if (exp_q.size() == 0) chk("idle_vld", m_tvalid, 0);
      end
      if (!rst_n) begin
         exp_q.delete();
         cur.delete();
         occ = 0; pkt_m = 0; drops_m = 0;
         in_pkt = 0; accepting = 0; rdy_exp = 0; prev_stall = 0;
      end else begin
         if (s_tvalid && rdy_exp) model_beat({s_tdata, s_tkeep, s_tlast, s_tuser}, s_tlast);
         if (m_tvalid && m_tready && exp_q.size() > 0) begin
            chk("beat", out, exp_q[0]);
            if (exp_q[0][UW] == 1'b1) pkt_m--;
            void'(exp_q.pop_front());
            occ--;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_out   = out;
         rdy_exp    = 1;
      end
      armed = 1;
   end

   // ---------------- m_tready driver ----------------
   bit rand_rdy = 0, rdy_fixed = 0;
   always @(posedge clk) begin
      #1;
      m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [UW-1:0] u);
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_pkt(input int len, input int id);
      for (int i = 0; i < len; i++)
         send_beat({16'(id), 16'(i), 32'($urandom())}, KW'($urandom()), (i == len - 1), UW'($urandom()));
   endtask

   task automatic drain(input string nm);
      bit done = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         tick();
         if (exp_q.size() == 0 && !m_tvalid && !in_pkt) done = 1;
      end
      chk({nm, "_drain_done"}, done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // 1-beat packet, 2-clk latency
      rdy_fixed = 1;
      tick(); tick();
      send_beat(64'hA5A5, '1, 1'b1, 10'h3);
      @(negedge clk);
      chk("p1_cnt_after_commit", pkt_cnt, 1);
      chk("p1_vld_e0", m_tvalid, 0);
      @(negedge clk);
      chk("p1_vld_e1", m_tvalid, 0);
      @(negedge clk);
      chk("p1_vld_e2", m_tvalid, 1);
      chk("p1_last", m_tlast, 1);
      chk("p1_data", m_tdata, 64'hA5A5);
      @(negedge clk);
      chk("p1_cnt_after_pop", pkt_cnt, 0);
      chk("p1_vld_after_pop", m_tvalid, 0);
      @(posedge clk); #1;

      // 4-beat packet held until commit
      rdy_fixed = 0;
      tick(); tick();
      for (int i = 0; i < 4; i++) send_beat(DW'(100 + i), '1, (i == 3), UW'(i));
      tick(); tick(); tick();
      @(negedge clk);
      chk("p4_vld", m_tvalid, 1);
      chk("p4_first_data", m_tdata, 100);
      chk("p4_first_last", m_tlast, 0);
      @(posedge clk); #1;
      rdy_fixed = 1;
      drain("p4");

      // Fill: five 16-beat packets, fifth dropped
      rdy_fixed = 0;
      tick(); tick();
      for (int p = 0; p < 5; p++) send_pkt(16, 200 + p);
      tick(); tick(); tick();
      @(negedge clk);
      chk("fill_pkt_cnt", pkt_cnt, 4);
      chk("fill_drop_cnt", drop_cnt, DCE);
      @(posedge clk); #1;
      rdy_fixed = 1;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (pkt_cnt == 3) hit = 1;
      end
      chk("fill_drain_one", hit, 1);
      rdy_fixed = 0;
      tick(); tick();
      send_pkt(16, 300);
      tick(); tick();
      @(negedge clk);
      chk("refill_pkt_cnt", pkt_cnt, 4);
      chk("refill_drop_cnt", drop_cnt, DCE);
      @(posedge clk); #1;
      rdy_fixed = 1;
      drain("fill");

      // Oversize packet followed by a legal one
      send_pkt(17, 400);
      send_pkt(2, 401);
      drain("over");
      @(negedge clk);
      chk("over_drop_cnt", drop_cnt, 2 * DCE);
      @(posedge clk); #1;

      // Randomized back-to-back traffic
      rand_rdy = 1;
      for (int p = 0; p < 100; p++) begin
         hit = 0;
         for (int i = 0; i < 500 && !hit; i++) begin
            if (occ <= DEPTH - MAXB) hit = 1;
            else tick();
         end
         chk("rand_space_wait", hit, 1);
         send_pkt($urandom_range(1, MAXB), 500 + p);
      end
      drain("rand");
      rand_rdy = 0;
      rdy_fixed = 1;
      tick();

      // Reset mid-packet with two packets buffered
      rdy_fixed = 0;
      tick(); tick();
      send_pkt(3, 700);
      send_pkt(2, 701);
      send_beat(64'h1, '1, 1'b0, '0);
      send_beat(64'h2, '1, 1'b0, '0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_vld", m_tvalid, 0);
      chk("mid_rst_pkt_cnt", pkt_cnt, 0);
      @(posedge clk); #1;
      send_pkt(3, 702);
      tick(); tick();
      @(negedge clk);
      chk("post_rst_pkt_cnt", pkt_cnt, 1);
      @(posedge clk); #1;
      rdy_fixed = 1;
      drain("post_rst");
      @(negedge clk);
      chk("post_rst_drop_cnt", drop_cnt, 0);
      chk("leftover", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
